// File: rtl/l1_icache.sv
// rtl/l1_icache.sv - direct-mapped L1 instruction cache with line fill FSM
//
// Purpose: read-only, direct-mapped instruction cache. Hits answer one cycle
// after the lookup; misses fetch the whole line word by word from memory,
// then answer from the refilled line.
//
// Ports:
//   mclk, reset          clock (rising edge) and asynchronous active-low reset
//   fetch_req/fetch_addr fetch request and byte address (bits [1:0] ignored)
//   fetch_data/fetch_ack instruction word and its one-cycle completion pulse
//   flush                one-cycle pulse invalidating every line
//   busy                 high while filling or responding after a fill
//   mem_*                word-read memory port used for line fills
//   hit_count/miss_count wrapping counters of accepted lookups
module l1_icache #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [31:0]           fetch_data,
  output logic                  fetch_ack,
  input  logic                  flush,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rw_req,
  output logic                  mem_rw,
  output logic [1:0]            mem_size,
  input  logic [31:0]           mem_read_data,
  input  logic                  mem_rec,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                  state, state_next;
  logic [SETS-1:0]         valid;
  logic [TAG_W-1:0]        tag_mem  [SETS];
  logic [31:0]             data_mem [SETS][LINE_WORDS];
  logic                    flush_pending;
  logic [ADDR_WIDTH-1:2]   req_addr;
  logic [OFF_W-1:0]        fill_word;

  logic [OFF_W-1:0]        lk_word, req_word;
  logic [IDX_W-1:0]        lk_set, fill_set;
  logic [TAG_W-1:0]        lk_tag, fill_tag;
  logic                    hit, miss, fill_we, fill_last;
  logic                    unused_addr_bits;

  assign lk_word  = fetch_addr[2 +: OFF_W];
  assign lk_set   = fetch_addr[2 + OFF_W +: IDX_W];
  assign lk_tag   = fetch_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_word = req_addr[2 +: OFF_W];
  assign fill_set = req_addr[2 + OFF_W +: IDX_W];
  assign fill_tag = req_addr[ADDR_WIDTH-1:TAG_LSB];
  assign unused_addr_bits = ^fetch_addr[1:0];

  assign busy     = (state == FILL) || (state == RESP);
  assign mem_rw   = 1'b0;
  assign mem_size = 2'd2;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // While fetch_ack is high the requester is still holding the request it
  // just had answered, so that cycle is never treated as a fresh lookup.
  // A flush in the same cycle as a lookup forces a miss.
  always_comb begin
    state_next = state;
    hit        = 1'b0;
    miss       = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req && !fetch_ack) begin
          if (!flush && valid[lk_set] && (tag_mem[lk_set] == lk_tag)) begin
            hit = 1'b1;
          end else begin
            miss       = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (mem_rec) begin
          fill_we = 1'b1;
          if (fill_word == OFF_W'(LINE_WORDS - 1)) begin
            fill_last  = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      valid         <= '0;
      flush_pending <= 1'b0;
      fetch_ack     <= 1'b0;
      fetch_data    <= '0;
      mem_rw_req    <= 1'b0;
      mem_address   <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      fill_word     <= '0;
      req_addr      <= '0;
    end else begin
      fetch_ack <= 1'b0;
      if (state == IDLE && flush) valid <= '0;
      if (state != IDLE && flush) flush_pending <= 1'b1;
      if (hit) begin
        fetch_ack  <= 1'b1;
        fetch_data <= data_mem[lk_set][lk_word];
        hit_count  <= hit_count + 32'd1;
      end
      if (miss) begin
        miss_count  <= miss_count + 32'd1;
        req_addr    <= fetch_addr[ADDR_WIDTH-1:2];
        mem_rw_req  <= 1'b1;
        mem_address <= {fetch_addr[ADDR_WIDTH-1:2+OFF_W], {(OFF_W+2){1'b0}}};
        fill_word   <= '0;
      end
      if (fill_we) begin
        fill_word                 <= fill_word + 1'b1;
        mem_address[2 +: OFF_W]   <= mem_address[2 +: OFF_W] + 1'b1;
      end
      // A flush seen at any point during the fill discards the new line too.
      if (fill_last) begin
        mem_rw_req <= 1'b0;
        if (flush || flush_pending) begin
          valid         <= '0;
          flush_pending <= 1'b0;
        end else begin
          valid[fill_set] <= 1'b1;
        end
      end
      if (state == RESP) begin
        fetch_ack  <= 1'b1;
        fetch_data <= data_mem[fill_set][req_word];
        if (flush || flush_pending) begin
          valid         <= '0;
          flush_pending <= 1'b0;
        end
      end
    end
  end

  // Data and tag storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge mclk) begin
    if (fill_we)   data_mem[fill_set][fill_word] <= mem_read_data;
    if (fill_last) tag_mem[fill_set] <= fill_tag;
  end

endmodule

// File: doc/l1_icache.md
L1_ICACHE -- requirements
Module: l1_icache

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped sets; power of two, 2..256.
REQ-002 Parameter LINE_WORDS, default 8, 32-bit words per line; power of two, 2..16.
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width; tag = fetch_addr[ADDR_WIDTH-1 : 2+log2(LINE_WORDS)+log2(SETS)].
REQ-004 mclk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 fetch_req  in  1  instruction fetch request, held high until fetch_ack.
REQ-007 fetch_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored; stable while fetch_req high.
REQ-008 fetch_data  out  32  instruction word, valid when fetch_ack high.
REQ-009 fetch_ack  out  1  one-cycle pulse completing a fetch.
REQ-010 flush  in  1  single-cycle pulse invalidating all lines.
REQ-011 busy  out  1  high in FILL and RESP states.
REQ-012 mem_address  out  ADDR_WIDTH  memory word address during fill.
REQ-013 mem_rw_req  out  1  memory request, held until mem_rec.
REQ-014 mem_rw  out  1  constant 0 (read).
REQ-015 mem_size  out  2  constant 2 (word).
REQ-016 mem_read_data  in  32  memory read data, valid with mem_rec.
REQ-017 mem_rec  in  1  memory completion, one cycle per word.
REQ-018 hit_count, miss_count  out  32 each  accepted-fetch hit and miss counters, wrapping.

Function
REQ-019 State machine SHALL have states IDLE, FILL and RESP.
REQ-020 Each set SHALL hold a valid bit, a tag and LINE_WORDS data words; lookup hits only when the valid bit is set and the tag matches.
REQ-021 In IDLE with fetch_req high and a hit, fetch_ack=1 with the addressed word on the next cycle, state remains IDLE, and hit_count increments.
REQ-022 In IDLE with fetch_req high and a miss, the next cycle SHALL be FILL with mem_rw_req=1, mem_address=line base (offset bits zero), and miss_count incremented.
REQ-023 In FILL, each mem_rec cycle SHALL write mem_read_data to word k of the set; mem_address advances by 4 the next cycle with mem_rw_req held high; k runs 0..LINE_WORDS-1.
REQ-024 On the final mem_rec, tag and valid SHALL be written, mem_rw_req deasserts next cycle, and state goes to RESP.
REQ-025 In RESP, fetch_ack=1 with the requested word (critical word taken from the filled line), then IDLE.
REQ-026 Miss latency SHALL be 1 + LINE_WORDS memory transactions + 1 cycle; hit latency SHALL be 1 cycle.
REQ-027 fetch_req high in the cycle after fetch_ack SHALL be treated as a new lookup.
REQ-028 flush in IDLE SHALL clear all valid bits on that edge; a simultaneous fetch_req is looked up after the flush (miss).
REQ-029 flush in FILL/RESP SHALL set flush_pending; when the fill completes the line is not validated, all valid bits clear, and fetch_ack/fetch_data are still delivered.
REQ-030 The address counter SHALL wrap within the line only at LINE_WORDS; the set index wraps modulo SETS; counters wrap 0xFFFFFFFF->0.
REQ-031 mem_rec SHALL be ignored outside FILL.
REQ-032 No simultaneous hit and fill: lookups are accepted only in IDLE.

Reset
REQ-033 On reset low, asynchronously: state=IDLE, all valid bits=0, flush_pending=0, fetch_ack=0, mem_rw_req=0, mem_address=0, fetch_data=0, hit_count=0, miss_count=0; data/tag arrays are not cleared.
REQ-034 Reset asserted mid-FILL SHALL abandon the fill, leaving the set invalid; the first request after release is a miss.

Verification
REQ-035 After reset, fetch 0x0000_00C0 with 1-cycle mem_rec -> mem addresses 0xC0..0xDC, ack 10 cycles after the request, miss_count=1.
REQ-036 Re-fetch 0xC4 -> ack next cycle with the word at 0xC4, no mem_rw_req, hit_count=1.
REQ-037 Fetch 0x2C0 (same set, different tag, defaults) -> miss, line refilled, a following 0xC0 misses again.
REQ-038 flush pulse then fetch 0xC0 -> miss; flush during FILL -> ack delivered, subsequent re-fetch misses.
REQ-039 Reset pulled low on the third mem_rec of a fill -> mem_rw_req=0 immediately, and the re-fetch misses.
REQ-040 SETS=4, LINE_WORDS=2, random addresses and memory stalls of 0-5 cycles -> every fetch_data matches the memory model.
